mc_ctrl_fsm: RTL and testbench

Sequential control unit for the multi-cycle MIPS CPU. It replaces the purely combinational ID-phase decoder with a full IF/ID/EX/MEM/WB state machine. It decodes the IR contents once in ID and holds the resulting control fields registered. It drives per-phase datapath strobes, waits on instruction- and data-memory ready handshakes with a timeout, resolves beq/bne from the ALU zero flag, and traps illegal opcodes into a sticky halt.

---
 rtl/mc_ctrl_fsm.sv | 266 ++++++++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control unit: IF/ID/EX/MEM/WB sequencer.
// Decodes IR once in ID, holds the control fields registered until the next ID,
// issues per-phase datapath strobes, bounds memory waits with a timeout, resolves
// beq/bne from alu_zero and traps halt/illegal/bus errors into an absorbing HALT.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   inst                IR contents (opcode inst[31:26], funct inst[5:0])
//   imem_ready          instruction fetch data valid
//   dmem_ready          data access complete
//   alu_zero            ALU result zero, sampled in EX
//   state               IF=0 ID=1 EX=2 MEM=3 WB=4 HALT=5
//   ir_write, pc_write  IR/PC load strobes; pc_src selects PC+4/branch/jump
//   reg_dst, alu_src1, alu_src2, alu_ctrl, mem_to_reg   registered decode fields
//   mem_read, mem_write, reg_write                       datapath strobes
//   instr_done          pulse on last cycle of a retired instruction
//   halted, illegal, bus_err                             sticky status
module mc_ctrl_fsm #(
  parameter int unsigned INST_W      = 32,
  parameter int unsigned ALUC_W      = 4,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [INST_W-1:0] inst,
  input  logic              imem_ready,
  input  logic              dmem_ready,
  input  logic              alu_zero,
  output logic [2:0]        state,
  output logic              ir_write,
  output logic              pc_write,
  output logic [1:0]        pc_src,
  output logic              reg_dst,
  output logic              alu_src1,
  output logic              alu_src2,
  output logic [ALUC_W-1:0] alu_ctrl,
  output logic              mem_read,
  output logic              mem_write,
  output logic              mem_to_reg,
  output logic              reg_write,
  output logic              instr_done,
  output logic              halted,
  output logic              illegal,
  output logic              bus_err
);

  typedef enum logic [2:0] {
    StIf   = 3'b000,
    StId   = 3'b001,
    StEx   = 3'b010,
    StMem  = 3'b011,
    StWb   = 3'b100,
    StHalt = 3'b101
  } state_e;

  localparam logic [5:0] OpRtype = 6'h00, OpJ = 6'h02, OpBeq = 6'h04, OpBne = 6'h05;
  localparam logic [5:0] OpAddi = 6'h08, OpAndi = 6'h0C, OpOri = 6'h0D;
  localparam logic [5:0] OpLw = 6'h23, OpSw = 6'h2B, OpHalt = 6'h3F;
  localparam logic [5:0] FnSll = 6'h00, FnAdd = 6'h20, FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24, FnOr = 6'h25, FnSlt = 6'h2A;

  localparam logic [ALUC_W-1:0] AluAnd  = ALUC_W'(4'b0000);
  localparam logic [ALUC_W-1:0] AluOr   = ALUC_W'(4'b0001);
  localparam logic [ALUC_W-1:0] AluAdd  = ALUC_W'(4'b0010);
  localparam logic [ALUC_W-1:0] AluSub  = ALUC_W'(4'b0110);
  localparam logic [ALUC_W-1:0] AluSlt  = ALUC_W'(4'b0111);
  localparam logic [ALUC_W-1:0] AluSll  = ALUC_W'(4'b1100);
  localparam logic [ALUC_W-1:0] AluHalt = ALUC_W'(4'b1111);

  localparam logic [7:0] Timeout = 8'(MEM_TIMEOUT);

  state_e            state_q;
  logic [7:0]        wait_q;
  logic              reg_dst_q, alu_src1_q, alu_src2_q, mem_to_reg_q;
  logic [ALUC_W-1:0] alu_ctrl_q;
  logic              is_lw_q, is_sw_q, is_beq_q, is_bne_q;
  logic              illegal_q, bus_err_q;

  logic [5:0]        opcode, funct;
  logic              d_reg_dst, d_alu_src1, d_alu_src2, d_mem_to_reg;
  logic [ALUC_W-1:0] d_alu_ctrl;
  logic              d_lw, d_sw, d_beq, d_bne, d_j, d_halt, d_illegal;
  logic              unused_inst_bits;

  assign opcode           = inst[INST_W-1 -: 6];
  assign funct            = inst[5:0];
  assign unused_inst_bits = ^inst[INST_W-7:6];

  // Combinational decode of the IR; only consumed while in ID.
  always_comb begin
    d_reg_dst    = 1'b0;
    d_alu_src1   = 1'b0;
    d_alu_src2   = 1'b0;
    d_alu_ctrl   = AluAnd;
    d_mem_to_reg = 1'b0;
    d_lw         = 1'b0;
    d_sw         = 1'b0;
    d_beq        = 1'b0;
    d_bne        = 1'b0;
    d_j          = 1'b0;
    d_halt       = 1'b0;
    d_illegal    = 1'b0;
    case (opcode)
      OpRtype: begin
        d_reg_dst = 1'b1;
        case (funct)
          FnAdd:   d_alu_ctrl = AluAdd;
          FnSub:   d_alu_ctrl = AluSub;
          FnAnd:   d_alu_ctrl = AluAnd;
          FnOr:    d_alu_ctrl = AluOr;
          FnSlt:   d_alu_ctrl = AluSlt;
          FnSll: begin
            d_alu_ctrl = AluSll;
            d_alu_src1 = 1'b1;
          end
          default: begin
            d_reg_dst = 1'b0;
            d_illegal = 1'b1;
          end
        endcase
      end
      OpAddi: begin d_alu_src2 = 1'b1; d_alu_ctrl = AluAdd; end
      OpAndi: begin d_alu_src2 = 1'b1; d_alu_ctrl = AluAnd; end
      OpOri:  begin d_alu_src2 = 1'b1; d_alu_ctrl = AluOr;  end
      OpLw: begin
        d_alu_src2   = 1'b1;
        d_alu_ctrl   = AluAdd;
        d_mem_to_reg = 1'b1;
        d_lw         = 1'b1;
      end
      OpSw:   begin d_alu_src2 = 1'b1; d_alu_ctrl = AluAdd; d_sw = 1'b1; end
      OpBeq:  begin d_alu_ctrl = AluSub; d_beq = 1'b1; end
      OpBne:  begin d_alu_ctrl = AluSub; d_bne = 1'b1; end
      OpJ:    d_j = 1'b1;
      OpHalt: begin d_alu_ctrl = AluHalt; d_halt = 1'b1; end
      default: d_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIf;
      wait_q       <= '0;
      reg_dst_q    <= 1'b0;
      alu_src1_q   <= 1'b0;
      alu_src2_q   <= 1'b0;
      alu_ctrl_q   <= '0;
      mem_to_reg_q <= 1'b0;
      is_lw_q      <= 1'b0;
      is_sw_q      <= 1'b0;
      is_beq_q     <= 1'b0;
      is_bne_q     <= 1'b0;
      illegal_q    <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      case (state_q)
        StIf: begin
          // A ready on the timeout cycle itself still wins.
          if (imem_ready) begin
            wait_q  <= '0;
            state_q <= StId;
          end else if (wait_q == Timeout) begin
            state_q   <= StHalt;
            bus_err_q <= 1'b1;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        StId: begin
          reg_dst_q    <= d_reg_dst;
          alu_src1_q   <= d_alu_src1;
          alu_src2_q   <= d_alu_src2;
          alu_ctrl_q   <= d_alu_ctrl;
          mem_to_reg_q <= d_mem_to_reg;
          is_lw_q      <= d_lw;
          is_sw_q      <= d_sw;
          is_beq_q     <= d_beq;
          is_bne_q     <= d_bne;
          if (d_illegal) begin
            state_q   <= StHalt;
            illegal_q <= 1'b1;
          end else if (d_halt) begin
            state_q <= StHalt;
          end else if (d_j) begin
            state_q <= StIf;
          end else begin
            state_q <= StEx;
          end
        end
        StEx: begin
          if (is_beq_q || is_bne_q)    state_q <= StIf;
          else if (is_lw_q || is_sw_q) state_q <= StMem;
          else                         state_q <= StWb;
        end
        StMem: begin
          if (dmem_ready) begin
            wait_q  <= '0;
            state_q <= is_lw_q ? StWb : StIf;
          end else if (wait_q == Timeout) begin
            state_q   <= StHalt;
            bus_err_q <= 1'b1;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        StWb:    state_q <= StIf;
        StHalt:  state_q <= StHalt;
        default: state_q <= StHalt;
      endcase
    end
  end

  // Strobes: decoded from state, registered fields and the phase's handshake input.
  always_comb begin
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    instr_done = 1'b0;
    case (state_q)
      StIf: begin
        ir_write = imem_ready;
        pc_write = imem_ready;
      end
      StId: begin
        if (d_j) begin
          pc_write   = 1'b1;
          pc_src     = 2'b10;
          instr_done = 1'b1;
        end else if (d_halt) begin
          instr_done = 1'b1;
        end
      end
      StEx: begin
        if (is_beq_q || is_bne_q) begin
          pc_write   = is_beq_q ? alu_zero : ~alu_zero;
          pc_src     = 2'b01;
          instr_done = 1'b1;
        end
      end
      StMem: begin
        mem_read   = is_lw_q;
        mem_write  = is_sw_q;
        instr_done = is_sw_q & dmem_ready;
      end
      StWb: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign state      = state_q;
  assign reg_dst    = reg_dst_q;
  assign alu_src1   = alu_src1_q;
  assign alu_src2   = alu_src2_q;
  assign alu_ctrl   = alu_ctrl_q;
  assign mem_to_reg = mem_to_reg_q;
  assign halted     = (state_q == StHalt);
  assign illegal    = illegal_q;
  assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: builds an expected per-cycle trace for each instruction
// from its class, latency and wait-state rules, then replays it against the DUT.
module tb_mc_ctrl_fsm;

  localparam int T = 15;
  localparam int C_ALU = 0, C_LW = 1, C_SW = 2, C_BEQ = 3, C_BNE = 4;
  localparam int C_J = 5, C_HALT = 6, C_ILL = 7;
  localparam logic [2:0] S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3;
  localparam logic [2:0] S_WB = 3'd4, S_HALT = 3'd5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] inst = '0;
  logic        imem_ready = 1'b0, dmem_ready = 1'b0, alu_zero = 1'b0;
  logic [2:0]  state;
  logic        ir_write, pc_write, reg_dst, alu_src1, alu_src2;
  logic [1:0]  pc_src;
  logic [3:0]  alu_ctrl;
  logic        mem_read, mem_write, mem_to_reg, reg_write, instr_done;
  logic        halted, illegal, bus_err;

  int checks = 0;
  int errors = 0;

  mc_ctrl_fsm #(.INST_W(32), .ALUC_W(4), .MEM_TIMEOUT(T)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .inst       (inst),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .alu_zero   (alu_zero),
    .state      (state),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .reg_dst    (reg_dst),
    .alu_src1   (alu_src1),
    .alu_src2   (alu_src2),
    .alu_ctrl   (alu_ctrl),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .instr_done (instr_done),
    .halted     (halted),
    .illegal    (illegal),
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  logic [13:0] obs;
  logic [7:0]  obs_f;
  assign obs   = {state, ir_write, pc_write, pc_src, mem_read, mem_write, reg_write,
                  instr_done, halted, illegal, bus_err};
  assign obs_f = {alu_ctrl, alu_src1, alu_src2, reg_dst, mem_to_reg};

  typedef struct {
    logic        imem;
    logic        dmem;
    logic        zero;
    logic [31:0] ins;
    logic [13:0] exp;
    bit          post;
  } cyc_t;

  cyc_t       tq[$];
  logic [7:0] cur_f, cur_m, held_f, held_m;
  bit         reached_id;

  function automatic logic rb();
    return ($urandom_range(0, 1) == 1);
  endfunction

  function automatic logic [13:0] mk(input logic [2:0] st, input logic irw, input logic pcw,
                                     input logic [1:0] ps, input logic mr, input logic mw,
                                     input logic rw, input logic dn, input logic h,
                                     input logic il, input logic be);
    return {st, irw, pcw, ps, mr, mw, rw, dn, h, il, be};
  endfunction

  // Instruction class plus expected {alu_ctrl, src1, src2, reg_dst, mem_to_reg}
  // and a mask of which of those fields are meaningful for the class.
  function automatic void ref_decode(input logic [31:0] i, output int cls,
                                     output logic [7:0] f, output logic [7:0] m);
    logic [5:0] op, fn;
    op = i[31:26];
    fn = i[5:0];
    cls = C_ILL;
    f = '0;
    case (op)
      6'h00: begin
        case (fn)
          6'h20: begin cls = C_ALU; f = {4'b0010, 4'b0010}; end
          6'h22: begin cls = C_ALU; f = {4'b0110, 4'b0010}; end
          6'h24: begin cls = C_ALU; f = {4'b0000, 4'b0010}; end
          6'h25: begin cls = C_ALU; f = {4'b0001, 4'b0010}; end
          6'h2A: begin cls = C_ALU; f = {4'b0111, 4'b0010}; end
          6'h00: begin cls = C_ALU; f = {4'b1100, 4'b1010}; end
          default: ;
        endcase
      end
      6'h08: begin cls = C_ALU;  f = {4'b0010, 4'b0100}; end
      6'h0C: begin cls = C_ALU;  f = {4'b0000, 4'b0100}; end
      6'h0D: begin cls = C_ALU;  f = {4'b0001, 4'b0100}; end
      6'h23: begin cls = C_LW;   f = {4'b0010, 4'b0101}; end
      6'h2B: begin cls = C_SW;   f = {4'b0010, 4'b0100}; end
      6'h04: begin cls = C_BEQ;  f = {4'b0110, 4'b0000}; end
      6'h05: begin cls = C_BNE;  f = {4'b0110, 4'b0000}; end
      6'h02: cls = C_J;
      6'h3F: begin cls = C_HALT; f = {4'b1111, 4'b0000}; end
      default: ;
    endcase
    case (cls)
      C_ALU, C_LW:         m = 8'hFF;
      C_SW, C_BEQ, C_BNE:  m = 8'hFC;
      C_HALT:              m = 8'hF0;
      default:             m = 8'h00;
    endcase
  endfunction

  task automatic push(input logic im, input logic dm, input logic z, input logic [31:0] i,
                      input logic [13:0] e, input bit p);
    cyc_t c;
    c.imem = im; c.dmem = dm; c.zero = z; c.ins = i; c.exp = e; c.post = p;
    tq.push_back(c);
  endtask

  // Expected cycle trace for one instruction: iw/dw are wait cycles before ready.
  task automatic build(input logic [31:0] ins, input int iw, input int dw, input logic z);
    int   cls;
    bit   hl, il, be;
    logic taken;
    hl = 0; il = 0; be = 0;
    ref_decode(ins, cls, cur_f, cur_m);
    tq.delete();
    reached_id = (iw <= T);
    for (int c = 0; c <= iw && c <= T; c++) begin
      if (c == iw) push(1'b1, rb(), rb(), $urandom(), mk(S_IF,1,1,2'b00,0,0,0,0,0,0,0), 0);
      else         push(1'b0, rb(), rb(), $urandom(), mk(S_IF,0,0,2'b00,0,0,0,0,0,0,0), 0);
    end
    if (iw > T) begin
      be = 1;
    end else begin
      if (cls == C_J) begin
        push(rb(), rb(), rb(), ins, mk(S_ID,0,1,2'b10,0,0,0,1,0,0,0), 0);
      end else if (cls == C_HALT) begin
        push(rb(), rb(), rb(), ins, mk(S_ID,0,0,2'b00,0,0,0,1,0,0,0), 0);
        hl = 1;
      end else if (cls == C_ILL) begin
        push(rb(), rb(), rb(), ins, mk(S_ID,0,0,2'b00,0,0,0,0,0,0,0), 0);
        hl = 1; il = 1;
      end else begin
        push(rb(), rb(), rb(), ins, mk(S_ID,0,0,2'b00,0,0,0,0,0,0,0), 0);
        if (cls == C_BEQ || cls == C_BNE) begin
          taken = (cls == C_BEQ) ? z : !z;
          push(rb(), rb(), z, ins, mk(S_EX,0,taken,2'b01,0,0,0,1,0,0,0), 1);
        end else begin
          push(rb(), rb(), rb(), ins, mk(S_EX,0,0,2'b00,0,0,0,0,0,0,0), 1);
          if (cls == C_LW || cls == C_SW) begin
            for (int c = 0; c <= dw && c <= T; c++) begin
              push(rb(), (c == dw), rb(), ins,
                   mk(S_MEM, 0, 0, 2'b00, cls == C_LW, cls == C_SW, 0,
                      (cls == C_SW) && (c == dw), 0, 0, 0), 1);
            end
            if (dw > T) be = 1;
          end
          if (cls == C_ALU || (cls == C_LW && dw <= T))
            push(rb(), rb(), rb(), ins, mk(S_WB,0,0,2'b00,0,0,1,1,0,0,0), 1);
        end
      end
    end
    if (be || hl) begin
      for (int c = 0; c < 20; c++)
        push(rb(), rb(), rb(), $urandom(), mk(S_HALT,0,0,2'b00,0,0,0,0,1,il,be), reached_id);
    end
  endtask

  // Starts and ends just after a falling edge; one trace entry per clock.
  task automatic run_trace(input string name);
    logic [7:0] ef, em;
    for (int k = 0; k < tq.size(); k++) begin
      imem_ready = tq[k].imem;
      dmem_ready = tq[k].dmem;
      alu_zero   = tq[k].zero;
      inst       = tq[k].ins;
      #1;
      checks++;
      if (obs !== tq[k].exp) begin
        errors++;
        $display("FAIL %s cycle %0d outputs got %b want %b", name, k, obs, tq[k].exp);
      end
      ef = tq[k].post ? cur_f : held_f;
      em = tq[k].post ? cur_m : held_m;
      if (em != 8'h00) begin
        checks++;
        if ((obs_f & em) !== (ef & em)) begin
          errors++;
          $display("FAIL %s cycle %0d fields got %b want %b mask %b", name, k, obs_f, ef, em);
        end
      end
      @(negedge clk);
    end
    if (reached_id) begin
      held_f = cur_f;
      held_m = cur_m;
    end
  endtask

  task automatic run_instr(input logic [31:0] ins, input int iw, input int dw, input logic z,
                           input string name);
    build(ins, iw, dw, z);
    run_trace(name);
  endtask

  task automatic do_reset();
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    rst_n      = 1'b0;
    #1;
    checks++;
    if (obs !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b want %b", obs, 14'd0);
    end
    checks++;
    if (obs_f !== 8'd0) begin
      errors++;
      $display("FAIL reset_fields got %b want %b", obs_f, 8'd0);
    end
    @(negedge clk);
    rst_n  = 1'b1;
    held_f = 8'h00;
    held_m = 8'hFF;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] i;
    i = $urandom();
    case ($urandom_range(0, 8))
      0: begin
        i[31:26] = 6'h00;
        case ($urandom_range(0, 5))
          0: i[5:0] = 6'h20;
          1: i[5:0] = 6'h22;
          2: i[5:0] = 6'h24;
          3: i[5:0] = 6'h25;
          4: i[5:0] = 6'h2A;
          default: i[5:0] = 6'h00;
        endcase
      end
      1: i[31:26] = 6'h08;
      2: i[31:26] = 6'h0C;
      3: i[31:26] = 6'h0D;
      4: i[31:26] = 6'h23;
      5: i[31:26] = 6'h2B;
      6: i[31:26] = 6'h04;
      7: i[31:26] = 6'h05;
      default: i[31:26] = 6'h02;
    endcase
    return i;
  endfunction

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_alu();
    run_instr(32'h0022_1820, 0, 0, 1'b0, "add");
    run_instr(32'h0022_1822, 0, 0, 1'b1, "sub");
    run_instr(32'h0022_1824, 1, 0, 1'b0, "and");
    run_instr(32'h0022_1825, 0, 0, 1'b0, "or");
    run_instr(32'h0022_182A, 2, 0, 1'b0, "slt");
    run_instr(32'h0002_1880, 0, 0, 1'b0, "sll");
    run_instr(32'h2022_0005, 0, 0, 1'b0, "addi");
    run_instr(32'h3022_00FF, 0, 0, 1'b0, "andi");
    run_instr(32'h3422_0F00, 0, 0, 1'b0, "ori");
  endtask

  task automatic test_mem();
    run_instr(32'h8C22_0004, 0, 3, 1'b0, "lw_wait3");
    run_instr(32'hAC22_0004, 0, 2, 1'b0, "sw_wait2");
    run_instr(32'h8C22_0008, 0, 0, 1'b0, "lw_nowait");
  endtask

  task automatic test_branch();
    run_instr(32'h1022_0003, 0, 0, 1'b1, "beq_taken");
    run_instr(32'h1022_0003, 0, 0, 1'b0, "beq_not_taken");
    run_instr(32'h1422_0003, 0, 0, 1'b1, "bne_not_taken");
    run_instr(32'h1422_0003, 0, 0, 1'b0, "bne_taken");
    run_instr(32'h0800_0010, 0, 0, 1'b0, "j");
    run_instr(32'h0022_1820, 0, 0, 1'b0, "add_after_j");
  endtask

  task automatic test_halt();
    run_instr(32'hFC00_0000, 0, 0, 1'b0, "halt_op");
    do_reset();
    run_instr(32'hF800_0000, 0, 0, 1'b0, "illegal_op3e");
    do_reset();
    run_instr(32'h0022_183F, 0, 0, 1'b0, "illegal_funct");
    do_reset();
  endtask

  task automatic test_timeout();
    run_instr(32'h0022_1820, T, 0, 1'b0, "imem_ready_at_limit");
    run_instr(32'h8C22_0004, 0, T, 1'b0, "dmem_ready_at_limit");
    run_instr(32'h0022_1820, 1000, 0, 1'b0, "imem_timeout");
    do_reset();
    run_instr(32'hAC22_0004, 0, 1000, 1'b0, "dmem_timeout");
    do_reset();
  endtask

  task automatic test_reset_mid_mem();
    build(32'h8C22_0004, 0, 10, 1'b0);
    while (tq.size() > 6) void'(tq.pop_back());
    run_trace("lw_before_reset");
    checks++;
    if ({state, mem_read} !== {S_MEM, 1'b1}) begin
      errors++;
      $display("FAIL mid_mem_state got %b want %b", {state, mem_read}, {S_MEM, 1'b1});
    end
    do_reset();
    run_instr(32'h0022_1820, 0, 0, 1'b0, "add_after_reset");
  endtask

  task automatic test_back_to_back();
    logic [31:0] ins;
    int iw, dw;
    for (int n = 0; n < 150; n++) begin
      ins = rand_inst();
      iw  = ($urandom_range(0, 9) == 0) ? T : int'($urandom_range(0, 2));
      dw  = ($urandom_range(0, 9) == 0) ? T : int'($urandom_range(0, 3));
      run_instr(ins, iw, dw, rb(), $sformatf("rand%0d_%h", n, ins));
    end
  endtask

  initial begin
    held_f = 8'h00;
    held_m = 8'hFF;
    test_reset();
    test_alu();
    test_mem();
    test_branch();
    test_halt();
    test_timeout();
    test_reset_mid_mem();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
